// File: rtl/inst_fetch_pkg.sv
// Shared types for the instruction fetch unit: bus/instruction words, the NOP
// encoding and the prefetch buffer entry.
package inst_fetch_pkg;

  typedef logic [31:0] dataBus_u;
  typedef logic [31:0] instruction_u;

  localparam instruction_u INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    dataBus_u     pc;
    instruction_u instruction;
    logic         misaligned;
  } if_entry_t;

endpackage

// File: rtl/inst_fetch_fifo.sv
// Prefetch buffer between instruction memory and decode. Pointers carry an
// extra wrap bit so full and empty are distinguishable from the count.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  if_entry_t                     push_data_i,
  input  logic                          pop_i,
  input  logic                          flush_i,
  output if_entry_t                     head_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  if_entry_t   mem_q [FIFO_DEPTH];

  // Flush wins over any push or pop issued in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count_o == CNT_FULL);
  assign empty_o = (count_o == '0);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC register, imem request/retry, prefetch buffer to
// decode. Optional misaligned-redirect trapping via FETCH_MISALIGN_CHECK_EN.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         clk_en,
  input  logic         rst_n,
  output logic         imem_rd_en,
  output dataBus_u     imem_addr,
  input  instruction_u imem_instruction,
  input  logic         imem_ready,
  input  logic         br_taken,
  input  logic [31:0]  br_target,
  output logic         if_valid,
  input  logic         if_ready,
  output instruction_u if_instruction,
  output logic [31:0]  if_pc,
  output logic         if_misaligned
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0] pc_q, pc_d;
  logic        redirect, pop, fetch, fetch_push, fetch_ok;
  logic        fifo_push, fifo_full, fifo_empty;
  if_entry_t   fifo_wdata, fifo_head;
  logic [CW-1:0] unused_fifo_count;
  logic [31:0] target_pc;

  assign redirect = br_taken && clk_en;
  assign pop      = if_valid && if_ready && clk_en;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_MIS  = 2'd1;
  localparam logic [1:0] ST_IDLE = 2'd2;

  logic [1:0] fsm_q, fsm_d;
  logic       mis_push;

  assign target_pc = br_target;
  assign fetch_ok  = (fsm_q == ST_RUN);
  // The trap entry goes in the cycle after the redirect, once the flush is done.
  assign mis_push  = clk_en && !br_taken && (fsm_q == ST_MIS);

  always_comb begin
    fsm_d = fsm_q;
    if (redirect)      fsm_d = (br_target[1:0] != 2'b00) ? ST_MIS : ST_RUN;
    else if (mis_push) fsm_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= ST_RUN;
    else        fsm_q <= fsm_d;
  end
`else
  logic unused_target_bits;

  assign unused_target_bits = ^br_target[1:0];
  assign target_pc = {br_target[31:2], 2'b00};
  assign fetch_ok  = 1'b1;
`endif

  assign fetch      = rst_n && clk_en && !br_taken && fetch_ok && (!fifo_full || pop);
  assign fetch_push = fetch && imem_ready;
  assign imem_rd_en = fetch;
  assign imem_addr  = {2'b00, pc_q[31:2]};

  always_comb begin
    fifo_push  = fetch_push;
    fifo_wdata = '{pc: pc_q, instruction: imem_instruction, misaligned: 1'b0};
`ifdef FETCH_MISALIGN_CHECK_EN
    if (mis_push) begin
      fifo_push  = 1'b1;
      fifo_wdata = '{pc: pc_q, instruction: INSTR_NOP, misaligned: 1'b1};
    end
`endif
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect)        pc_d = target_pc;
    else if (fetch_push) pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (pop),
    .flush_i     (redirect),
    .head_o      (fifo_head),
    .count_o     (unused_fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Empty buffer presents a NOP at pc 0 so decode never sees stale data.
  assign if_valid       = !fifo_empty;
  assign if_instruction = fifo_empty ? INSTR_NOP : fifo_head.instruction;
  assign if_pc          = fifo_empty ? 32'h0 : fifo_head.pc;
  assign if_misaligned  = !fifo_empty && fifo_head.misaligned;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: queue-based reference model checked every
// cycle, plus hand-computed expectations for the main scenarios.
module tb_inst_fetch;

  localparam logic [31:0] NOP_W = 32'h0000_0013;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        clk_en, rst_n, imem_rd_en, imem_ready, br_taken;
  logic        if_valid, if_ready, if_misaligned;
  logic [31:0] imem_addr, imem_instruction, br_target, if_instruction, if_pc;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk              (clk),
    .clk_en           (clk_en),
    .rst_n            (rst_n),
    .imem_rd_en       (imem_rd_en),
    .imem_addr        (imem_addr),
    .imem_instruction (imem_instruction),
    .imem_ready       (imem_ready),
    .br_taken         (br_taken),
    .br_target        (br_target),
    .if_valid         (if_valid),
    .if_ready         (if_ready),
    .if_instruction   (if_instruction),
    .if_pc            (if_pc),
    .if_misaligned    (if_misaligned)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] widx);
    return {widx[15:0], ~widx[15:0]};
  endfunction

  assign imem_instruction = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte pc plus a queue of {misaligned, pc, instruction}.
  logic [31:0] m_pc   = 32'h0;
  logic        m_pend = 1'b0;
  logic        m_idle = 1'b0;
  logic [64:0] exp_q[$];

  function automatic logic m_rd();
    return rst_n && clk_en && !br_taken && !m_pend && !m_idle &&
           (exp_q.size() < DEPTH || (exp_q.size() > 0 && if_ready));
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic do_rd;
    if (!rst_n) begin
      m_pc   = 32'h0;
      m_pend = 1'b0;
      m_idle = 1'b0;
      exp_q.delete();
    end else if (clk_en) begin
      do_rd = m_rd();
      if (br_taken) begin
        exp_q.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
        m_pc   = br_target;
        m_pend = (br_target[1:0] != 2'b00);
        m_idle = (br_target[1:0] != 2'b00);
`else
        m_pc = br_target & 32'hFFFF_FFFC;
`endif
      end else if (m_pend) begin
        exp_q.push_back({1'b1, m_pc, NOP_W});
        m_pend = 1'b0;
      end else begin
        if (exp_q.size() > 0 && if_ready) void'(exp_q.pop_front());
        if (do_rd && imem_ready) begin
          exp_q.push_back({1'b0, m_pc, mem_word(m_pc >> 2)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [64:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : {1'b0, 32'h0, NOP_W};
    check("cyc_rd_en",  {31'b0, imem_rd_en}, {31'b0, m_rd()});
    check("cyc_addr",   imem_addr, m_pc >> 2);
    check("cyc_valid",  {31'b0, if_valid}, {31'b0, exp_q.size() > 0});
    check("cyc_pc",     if_pc, head[63:32]);
    check("cyc_instr",  if_instruction, head[31:0]);
    check("cyc_mis",    {31'b0, if_misaligned}, {31'b0, head[64]});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    cyc(); br_taken = 1'b1; br_target = tgt;
    cyc(); br_taken = 1'b0;
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; imem_ready = 1'b1; br_taken = 1'b0;
    br_target = 32'h0; if_ready = 1'b1;
    repeat (2) cyc();
    #1;
    check("rst_rd_en", {31'b0, imem_rd_en}, 32'h0);
    check("rst_valid", {31'b0, if_valid}, 32'h0);
    check("rst_instr", if_instruction, 32'h0000_0013);
    check("rst_pc",    if_pc, 32'h0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_mis",   {31'b0, if_misaligned}, 32'h0);

    // Streaming after reset release
    cyc(); rst_n = 1'b1; #1;
    check("s_addr0", imem_addr, 32'h0);
    check("s_rd0",   {31'b0, imem_rd_en}, 32'h1);
    cyc(); #1; check("s_addr1", imem_addr, 32'h1); check("s_pc0", if_pc, 32'h0);
    check("s_instr0", if_instruction, 32'h0000_FFFF);
    cyc(); #1; check("s_addr2", imem_addr, 32'h2); check("s_pc4", if_pc, 32'h4);
    cyc(); #1; check("s_pc8", if_pc, 32'h8);

    // Decode stall fills the buffer, fetch stops at pc 0x8
    cyc(); rst_n = 1'b0; #1;
    check("mid_rst_valid", {31'b0, if_valid}, 32'h0);
    check("mid_rst_addr",  imem_addr, 32'h0);
    cyc(); rst_n = 1'b1; if_ready = 1'b0;
    cyc(); cyc(); cyc(); #1;
    check("stall_rd",   {31'b0, imem_rd_en}, 32'h0);
    check("stall_addr", imem_addr, 32'h2);
    check("stall_pc",   if_pc, 32'h0);
    cyc(); if_ready = 1'b1; #1;
    check("resume_pc0", if_pc, 32'h0);
    check("resume_rd",  {31'b0, imem_rd_en}, 32'h1);
    cyc(); #1; check("resume_pc4", if_pc, 32'h4);

    // Memory not ready at pc 0x10
    cyc(); imem_ready = 1'b0; #1;
    check("nr_pc8", if_pc, 32'h8); check("nr_addr0", imem_addr, 32'h4);
    cyc(); cyc(); #1;
    check("nr_addr2",  imem_addr, 32'h4);
    check("nr_valid",  {31'b0, if_valid}, 32'h0);
    check("nr_rd",     {31'b0, imem_rd_en}, 32'h1);
    cyc(); imem_ready = 1'b1;
    cyc(); #1; check("nr_pc10", if_pc, 32'h10);

    // Clock enable low freezes everything, then reset while frozen
    cyc(); clk_en = 1'b0; #1;
    check("ce_rd", {31'b0, imem_rd_en}, 32'h0); check("ce_pc", if_pc, 32'h14);
    cyc(); cyc(); #1;
    check("ce_pc_hold", if_pc, 32'h14); check("ce_addr", imem_addr, 32'h6);
    rst_n = 1'b0; #1;
    check("ce_rst_valid", {31'b0, if_valid}, 32'h0);

    // Redirect with a full buffer
    cyc(); rst_n = 1'b1; clk_en = 1'b1; if_ready = 1'b0;
    cyc(); cyc(); #1;
    check("full_rd", {31'b0, imem_rd_en}, 32'h0);
    cyc(); br_taken = 1'b1; br_target = 32'h100; #1;
    check("br_rd", {31'b0, imem_rd_en}, 32'h0);
    cyc(); br_taken = 1'b0; if_ready = 1'b1; #1;
    check("br_addr", imem_addr, 32'h40);
    check("br_valid0", {31'b0, if_valid}, 32'h0);
    cyc(); #1; check("br_pc", if_pc, 32'h100);

    // Redirect coinciding with a pop: popped entry discarded
    cyc(); br_taken = 1'b1; br_target = 32'h200;
    cyc(); br_taken = 1'b0; #1;
    check("bp_valid0", {31'b0, if_valid}, 32'h0); check("bp_addr", imem_addr, 32'h80);
    cyc(); #1; check("bp_pc200", if_pc, 32'h200);
    cyc(); #1; check("bp_pc204", if_pc, 32'h204);

    // PC wrap at the top of the address space
    redirect(32'hFFFF_FFF8);
    cyc(); #1; check("wrap_f8", if_pc, 32'hFFFF_FFF8);
    cyc(); #1; check("wrap_fc", if_pc, 32'hFFFF_FFFC);
    cyc(); #1; check("wrap_0",  if_pc, 32'h0);

    // Misaligned redirect target
    redirect(32'h102); #1;
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mis_rd0", {31'b0, imem_rd_en}, 32'h0);
    cyc(); #1;
    check("mis_pc",    if_pc, 32'h102);
    check("mis_flag",  {31'b0, if_misaligned}, 32'h1);
    check("mis_instr", if_instruction, 32'h0000_0013);
    cyc(); #1;
    check("mis_idle_rd",    {31'b0, imem_rd_en}, 32'h0);
    check("mis_idle_valid", {31'b0, if_valid}, 32'h0);
`else
    check("mis_addr", imem_addr, 32'h40);
    cyc(); #1;
    check("mis_pc",   if_pc, 32'h100);
    check("mis_flag", {31'b0, if_misaligned}, 32'h0);
    cyc(); #1; check("mis_pc104", if_pc, 32'h104);
`endif
    repeat (3) cyc();

    // Recovery with an aligned redirect and random stall pattern
    redirect(32'h300);
    cyc(); #1; check("rec_pc", if_pc, 32'h300);
    for (int i = 0; i < 40; i++) begin
      cyc();
      if_ready   = ($urandom_range(0, 3) != 0);
      imem_ready = ($urandom_range(0, 3) != 0);
    end
    cyc(); if_ready = 1'b1; imem_ready = 1'b1;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
